// File: rtl/branch_hazard_forward_unit_if.sv
// Bundle between the ID-stage branch logic and the branch hazard/forward unit.
// The pipeline side is the master; the hazard unit is the slave.
interface branch_hazard_forward_unit_if #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic                   br_valid;
  logic [NUM_SRC*AW-1:0]  br_src;
  logic [AW-1:0]          idex_rd;
  logic                   idex_regwrite;
  logic                   idex_memread;
  logic [AW-1:0]          exmem_rd;
  logic                   exmem_regwrite;
  logic                   exmem_memread;
  logic [AW-1:0]          memwb_rd;
  logic                   memwb_regwrite;
  logic [2*NUM_SRC-1:0]   fwd_sel;
  logic                   stall;
  logic [CNT_W-1:0]       stall_cycles;

  modport master (
    output br_valid, br_src,
    output idex_rd, idex_regwrite, idex_memread,
    output exmem_rd, exmem_regwrite, exmem_memread,
    output memwb_rd, memwb_regwrite,
    input  fwd_sel, stall, stall_cycles
  );

  modport slave (
    input  br_valid, br_src,
    input  idex_rd, idex_regwrite, idex_memread,
    input  exmem_rd, exmem_regwrite, exmem_memread,
    input  memwb_rd, memwb_regwrite,
    output fwd_sel, stall, stall_cycles
  );
endinterface

// File: rtl/branch_hazard_forward_unit.sv
// ID-stage branch operand forwarding selects, load/ALU stall FSM and a
// saturating stall-cycle counter.
//
// state | meaning
// IDLE  | stall follows the live hazard cost (0 or 1 cycle needed)
// HOLD  | second stall cycle of a load-use hazard, inputs ignored
module branch_hazard_forward_unit #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input logic                           clock,
  input logic                           reset,
  branch_hazard_forward_unit_if.slave   bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [1:0]           rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [2*NUM_SRC-1:0] fwd_raw;
  logic [1:0]           need;
  logic [AW-1:0]        src_v;
  logic                 hit_idex, hit_exmem, hit_memwb;
  logic [1:0]           cost_v;
  logic                 stall_int;

  always_comb begin
    fwd_raw   = '0;
    need      = 2'd0;
    src_v     = '0;
    hit_idex  = 1'b0;
    hit_exmem = 1'b0;
    hit_memwb = 1'b0;
    cost_v    = 2'd0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_v     = bus.br_src[s*AW +: AW];
      hit_idex  = bus.idex_regwrite  && (bus.idex_rd  != '0) && (bus.idex_rd  == src_v);
      hit_exmem = bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == src_v);
      hit_memwb = bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == src_v);

      // A load in EX/MEM has no data yet, so it falls through to MEM/WB here;
      // the stall logic below keeps that select from ever being used.
      if (hit_exmem && !bus.exmem_memread)
        fwd_raw[2*s +: 2] = 2'b10;
      else if (hit_memwb)
        fwd_raw[2*s +: 2] = 2'b01;
      else
        fwd_raw[2*s +: 2] = 2'b00;

      if (hit_idex && bus.idex_memread)
        cost_v = 2'd2;
      else if (hit_idex)
        cost_v = 2'd1;
      else if (hit_exmem && bus.exmem_memread)
        cost_v = 2'd1;
      else
        cost_v = 2'd0;

      if (bus.br_valid && (cost_v > need))
        need = cost_v;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (need == 2'd2) begin
          rem_d   = 2'd1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        rem_d = rem_q - 2'd1;
        if (rem_q == 2'd1) begin
          rem_d   = 2'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    stall_int = 1'b0;
    if (!reset)
      stall_int = (state_q == HOLD) || (need != 2'd0);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_int && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall        = stall_int;
  assign bus.fwd_sel      = (reset || stall_int || !bus.br_valid) ? '0 : fwd_raw;
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_branch_hazard_forward_unit.sv
// Directed bench for branch_hazard_forward_unit: a vector table for the
// combinational cases plus hand sequences for stalls, reset and saturation.
module tb_branch_hazard_forward_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       br_valid;
  logic [9:0] br_src;
  logic [4:0] idex_rd, exmem_rd, memwb_rd;
  logic       idex_regwrite, idex_memread;
  logic       exmem_regwrite, exmem_memread, memwb_regwrite;

  int checks = 0;
  int errors = 0;

  branch_hazard_forward_unit_if #(.AW(5), .NUM_SRC(2), .CNT_W(16)) bus ();
  branch_hazard_forward_unit_if #(.AW(5), .NUM_SRC(2), .CNT_W(3))  bus_sat ();

  assign bus.br_valid           = br_valid;
  assign bus.br_src             = br_src;
  assign bus.idex_rd            = idex_rd;
  assign bus.idex_regwrite      = idex_regwrite;
  assign bus.idex_memread       = idex_memread;
  assign bus.exmem_rd           = exmem_rd;
  assign bus.exmem_regwrite     = exmem_regwrite;
  assign bus.exmem_memread      = exmem_memread;
  assign bus.memwb_rd           = memwb_rd;
  assign bus.memwb_regwrite     = memwb_regwrite;

  assign bus_sat.br_valid       = br_valid;
  assign bus_sat.br_src         = br_src;
  assign bus_sat.idex_rd        = idex_rd;
  assign bus_sat.idex_regwrite  = idex_regwrite;
  assign bus_sat.idex_memread   = idex_memread;
  assign bus_sat.exmem_rd       = exmem_rd;
  assign bus_sat.exmem_regwrite = exmem_regwrite;
  assign bus_sat.exmem_memread  = exmem_memread;
  assign bus_sat.memwb_rd       = memwb_rd;
  assign bus_sat.memwb_regwrite = memwb_regwrite;

  branch_hazard_forward_unit #(.AW(5), .NUM_SRC(2), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  branch_hazard_forward_unit #(.AW(5), .NUM_SRC(2), .CNT_W(3)) dut_sat (
    .clock (clock),
    .reset (reset),
    .bus   (bus_sat.slave)
  );

  typedef struct {
    string      name;
    logic       bv;
    logic [9:0] src;
    logic [4:0] ix_rd;  logic ix_rw; logic ix_mr;
    logic [4:0] ex_rd;  logic ex_rw; logic ex_mr;
    logic [4:0] wb_rd;  logic wb_rw;
    logic [3:0] exp_sel;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    br_valid = 1'b0; br_src = '0;
    idex_rd = '0;  idex_regwrite = 1'b0;  idex_memread = 1'b0;
    exmem_rd = '0; exmem_regwrite = 1'b0; exmem_memread = 1'b0;
    memwb_rd = '0; memwb_regwrite = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    int n_stall;
    int exp_sat;

    vecs[0]  = '{"alu_fwd",       1, {5'd9,5'd8}, 5'd0,0,0, 5'd8,1,0, 5'd9,1, 4'b0110, 0};
    vecs[1]  = '{"exmem_prio",    1, {5'd3,5'd8}, 5'd0,0,0, 5'd8,1,0, 5'd8,1, 4'b0010, 0};
    vecs[2]  = '{"zero_reg",      1, {5'd0,5'd0}, 5'd0,0,0, 5'd0,1,0, 5'd0,1, 4'b0000, 0};
    vecs[3]  = '{"no_valid",      0, {5'd9,5'd8}, 5'd0,0,0, 5'd8,1,0, 5'd9,1, 4'b0000, 0};
    vecs[4]  = '{"exmem_norw",    1, {5'd3,5'd8}, 5'd0,0,0, 5'd8,0,0, 5'd8,1, 4'b0001, 0};
    vecs[5]  = '{"idex_alu",      1, {5'd3,5'd8}, 5'd8,1,0, 5'd8,1,0, 5'd0,0, 4'b0000, 1};
    vecs[6]  = '{"exmem_load",    1, {5'd3,5'd8}, 5'd0,0,0, 5'd8,1,1, 5'd0,0, 4'b0000, 1};
    vecs[7]  = '{"exmem_load_wb", 1, {5'd3,5'd8}, 5'd0,0,0, 5'd8,1,1, 5'd8,1, 4'b0000, 1};
    vecs[8]  = '{"same_src",      1, {5'd8,5'd8}, 5'd0,0,0, 5'd8,1,0, 5'd0,0, 4'b1010, 0};
    vecs[9]  = '{"idex_norw",     1, {5'd3,5'd8}, 5'd8,0,1, 5'd0,0,0, 5'd8,1, 4'b0001, 0};
    vecs[10] = '{"load_norw",     1, {5'd3,5'd8}, 5'd0,0,0, 5'd8,0,1, 5'd0,0, 4'b0000, 0};
    vecs[11] = '{"idex_zero",     1, {5'd3,5'd0}, 5'd0,1,1, 5'd0,0,0, 5'd0,0, 4'b0000, 0};
    vecs[12] = '{"load_novalid",  0, {5'd3,5'd8}, 5'd8,1,1, 5'd0,0,0, 5'd0,0, 4'b0000, 0};
    vecs[13] = '{"mixed_srcs",    1, {5'd8,5'd4}, 5'd8,1,0, 5'd4,1,0, 5'd0,0, 4'b0000, 1};

    // reset: outputs quiet even with a live hazard on the inputs
    clear_in();
    reset = 1'b1;
    br_valid = 1'b1; br_src = {5'd0, 5'd8};
    idex_rd = 5'd8; idex_regwrite = 1'b1; idex_memread = 1'b1;
    next_cycle();
    #2;
    check("rst_stall", bus.stall, 0);
    check("rst_fwd",   bus.fwd_sel, 0);
    check("rst_cnt",   bus.stall_cycles, 0);
    reset = 1'b0;
    clear_in();

    n_stall = 0;
    for (int i = 0; i < 14; i++) begin
      br_valid = vecs[i].bv; br_src = vecs[i].src;
      idex_rd = vecs[i].ix_rd;  idex_regwrite = vecs[i].ix_rw;  idex_memread = vecs[i].ix_mr;
      exmem_rd = vecs[i].ex_rd; exmem_regwrite = vecs[i].ex_rw; exmem_memread = vecs[i].ex_mr;
      memwb_rd = vecs[i].wb_rd; memwb_regwrite = vecs[i].wb_rw;
      #2;
      check({vecs[i].name, "_sel"},   bus.fwd_sel, {28'd0, vecs[i].exp_sel});
      check({vecs[i].name, "_stall"}, bus.stall,   {31'd0, vecs[i].exp_stall});
      if (vecs[i].exp_stall) n_stall++;
      next_cycle();
    end
    clear_in();
    #2;
    exp_sat = (n_stall > 7) ? 7 : n_stall;
    check("table_cnt",     bus.stall_cycles, n_stall);
    check("table_cnt_sat", bus_sat.stall_cycles, exp_sat);

    // ALU result in ID/EX: one-cycle stall, then EX/MEM forward
    do_reset();
    br_valid = 1'b1; br_src = {5'd0, 5'd8};
    idex_rd = 5'd8; idex_regwrite = 1'b1;
    #2;
    check("alu_idex_stall", bus.stall, 1);
    check("alu_idex_sel",   bus.fwd_sel, 0);
    next_cycle();
    idex_rd = '0; idex_regwrite = 1'b0;
    exmem_rd = 5'd8; exmem_regwrite = 1'b1;
    #2;
    check("alu_next_stall", bus.stall, 0);
    check("alu_next_sel",   bus.fwd_sel, 4'b0010);
    check("alu_next_cnt",   bus.stall_cycles, 1);

    // load-use: IDLE stall then HOLD stall, then MEM/WB forward
    do_reset();
    br_valid = 1'b1; br_src = {5'd8, 5'd0};
    idex_rd = 5'd8; idex_regwrite = 1'b1; idex_memread = 1'b1;
    #2;
    check("lu_c1_stall", bus.stall, 1);
    next_cycle();
    idex_rd = '0; idex_regwrite = 1'b0; idex_memread = 1'b0;
    exmem_rd = 5'd8; exmem_regwrite = 1'b1; exmem_memread = 1'b1;
    #2;
    check("lu_c2_stall", bus.stall, 1);
    check("lu_c2_sel",   bus.fwd_sel, 0);
    next_cycle();
    exmem_rd = '0; exmem_regwrite = 1'b0; exmem_memread = 1'b0;
    memwb_rd = 5'd8; memwb_regwrite = 1'b1;
    #2;
    check("lu_c3_stall", bus.stall, 0);
    check("lu_c3_sel",   bus.fwd_sel, 4'b0100);
    check("lu_c3_cnt",   bus.stall_cycles, 2);

    // HOLD stalls even when the inputs show no hazard at all
    do_reset();
    br_valid = 1'b1; br_src = {5'd8, 5'd0};
    idex_rd = 5'd8; idex_regwrite = 1'b1; idex_memread = 1'b1;
    next_cycle();
    clear_in();
    #2;
    check("hold_ign_stall", bus.stall, 1);
    next_cycle();
    br_valid = 1'b1; br_src = {5'd8, 5'd0};
    memwb_rd = 5'd8; memwb_regwrite = 1'b1;
    #2;
    check("hold_end_stall", bus.stall, 0);
    check("hold_end_sel",   bus.fwd_sel, 4'b0100);
    check("hold_end_cnt",   bus.stall_cycles, 2);

    // load in EX/MEM: one-cycle stall with selects forced to regfile
    do_reset();
    br_valid = 1'b1; br_src = {5'd0, 5'd8};
    exmem_rd = 5'd8; exmem_regwrite = 1'b1; exmem_memread = 1'b1;
    #2;
    check("ldex_stall", bus.stall, 1);
    check("ldex_sel",   bus.fwd_sel, 0);
    next_cycle();
    exmem_rd = '0; exmem_regwrite = 1'b0; exmem_memread = 1'b0;
    memwb_rd = 5'd8; memwb_regwrite = 1'b1;
    #2;
    check("ldex_next_stall", bus.stall, 0);
    check("ldex_next_sel",   bus.fwd_sel, 4'b0001);
    check("ldex_next_cnt",   bus.stall_cycles, 1);

    // reset while in HOLD aborts the stall
    do_reset();
    br_valid = 1'b1; br_src = {5'd0, 5'd8};
    idex_rd = 5'd8; idex_regwrite = 1'b1; idex_memread = 1'b1;
    next_cycle();
    reset = 1'b1;
    idex_rd = '0; idex_regwrite = 1'b0; idex_memread = 1'b0;
    exmem_rd = 5'd8; exmem_regwrite = 1'b1; exmem_memread = 1'b1;
    #2;
    check("rhold_stall", bus.stall, 0);
    check("rhold_sel",   bus.fwd_sel, 0);
    next_cycle();
    reset = 1'b0;
    clear_in();
    br_valid = 1'b1; br_src = {5'd0, 5'd8};
    memwb_rd = 5'd8; memwb_regwrite = 1'b1;
    #2;
    check("rhold_after_stall", bus.stall, 0);
    check("rhold_after_sel",   bus.fwd_sel, 4'b0001);
    check("rhold_after_cnt",   bus.stall_cycles, 0);

    // held ALU hazard for 10 cycles: wide counter counts, narrow one saturates
    do_reset();
    br_valid = 1'b1; br_src = {5'd0, 5'd8};
    idex_rd = 5'd8; idex_regwrite = 1'b1;
    for (int n = 0; n < 10; n++) begin
      #2;
      exp_sat = (n > 7) ? 7 : n;
      check("sat_stall",    bus_sat.stall, 1);
      check("sat_cnt",      bus_sat.stall_cycles, exp_sat);
      check("sat_wide_cnt", bus.stall_cycles, n);
      next_cycle();
    end
    clear_in();
    #2;
    check("sat_final",      bus_sat.stall_cycles, 7);
    check("sat_wide_final", bus.stall_cycles, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_hazard_forward_unit.md
Name: branch_hazard_forward_unit

Overview:
Generalised branch-operand hazard unit for the ID-stage branch comparator. It resolves NUM_SRC branch source registers against the EX/MEM and MEM/WB producers and returns per-source forwarding selects. A stall FSM holds ID for the required number of cycles when a producer cannot be forwarded in time: an ALU result still in ID/EX, or a load in ID/EX or EX/MEM. A saturating counter records total branch-stall cycles for performance monitoring.

Parameters:
AW, 5, register address width
NUM_SRC, 2, number of branch source operands checked
CNT_W, 16, width of the stall-cycle statistics counter

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; clears FSM, counter, statistics
br_valid  in  1  ID holds a branch that consumes its sources this cycle
br_src  in  NUM_SRC*AW  branch source regs, source s at bits [s*AW +: AW]
idex_rd  in  AW  ID/EX destination
idex_regwrite  in  1  ID/EX writes a register
idex_memread  in  1  ID/EX is a load
exmem_rd  in  AW  EX/MEM destination
exmem_regwrite  in  1  EX/MEM writes a register
exmem_memread  in  1  EX/MEM is a load
memwb_rd  in  AW  MEM/WB destination
memwb_regwrite  in  1  MEM/WB writes a register
fwd_sel  out  2*NUM_SRC  per-source select at [2s +: 2]: 00 regfile, 01 MEM/WB, 10 EX/MEM
stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX
stall_cycles  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Register 0 never matches. A match requires rd!=0, rd==src, and the stage's regwrite=1.
- Forwarding is combinational. For each source: EX/MEM match that is not a load -> 10. Otherwise MEM/WB match -> 01. Otherwise 00. EX/MEM has priority over MEM/WB.
- When stall=1, or when br_valid=0, every fwd_sel field is 00.
- Per-source cost, evaluated only when br_valid=1:
  - ID/EX match with idex_memread=1 -> 2.
  - ID/EX match with idex_memread=0 -> 1.
  - Otherwise an EX/MEM match with exmem_memread=1 -> 1.
  - Otherwise 0.
- need = max of the per-source costs (0..2).
- FSM states are IDLE and HOLD, with a 2-bit remaining counter rem.
- IDLE:
  - stall = (need!=0).
  - need==2 -> rem<=1, go to HOLD.
  - need==1 -> stay in IDLE. The hazard is re-evaluated next cycle after the bubble.
  - need==0 -> stay in IDLE.
- HOLD:
  - stall=1 unconditionally; inputs are ignored.
  - rem decrements each cycle. When rem==1, go to IDLE (rem<=0).
  - Total stall for a load in ID/EX is 2 cycles: 1 in IDLE plus 1 in HOLD.
- stall is combinational in IDLE and state-driven in HOLD. While reset=1, stall=0.
- stall_cycles increments by 1 every clock edge where stall=1. It saturates at 2^CNT_W-1 and does not wrap.
- Reset values: state IDLE, rem 0, stall_cycles 0. Outputs during reset: stall 0, fwd_sel all 00.
- Reset asserted in HOLD aborts the stall. The first cycle after reset is IDLE and re-evaluates the inputs fresh.
- Simultaneous ID/EX and EX/MEM matches on different sources: the larger cost wins.
- Same register in EX/MEM and MEM/WB: EX/MEM is selected (youngest value).
- Sources equal to each other are each resolved independently and identically.

Test Plan:
- ALU forwarding: br_src={rt=9,rs=8}, exmem_rd=8 (regwrite, not load), memwb_rd=9 (regwrite) -> fwd_sel source0=10, source1=01; stall=0; stall_cycles unchanged.
- Priority and zero register: exmem_rd=memwb_rd=8, src0=8 -> 10. Then exmem_rd=memwb_rd=0 with src0=0 -> 00, no stall.
- ALU in ID/EX: idex_rd=8, regwrite=1, memread=0, src0=8 -> stall=1 for exactly 1 cycle. Next cycle the producer is in EX/MEM, stall=0, sel0=10. stall_cycles=1.
- Load-use: idex_rd=8, memread=1, src1=8. Inputs then advance as the pipeline does -> stall=1 for 2 consecutive cycles (IDLE, then HOLD ignoring inputs). Third cycle: memwb_rd=8, sel1=01, stall=0. stall_cycles=2.
- Load in EX/MEM: exmem_rd=8, memread=1, src0=8 -> 1-cycle stall, sel0 forced 00 during the stall. Next cycle memwb_rd=8 -> sel0=01.
- Reset mid-HOLD, and saturation with CNT_W=3: reset=1 during HOLD -> stall=0 that cycle, IDLE afterwards, counter=0. Hold a hazard for 10 stall cycles -> stall_cycles stops at 7.
